// File: rtl/ov7670_capture.sv
// OV7670 pixel capture: oversamples the camera bus in the clk domain,
// pairs bytes into RGB565 pixels and tags each one with x/y and a
// linear frame-buffer address. Capture always begins on a clean frame
// boundary, and sticky flags report bad line and frame geometry.
module ov7670_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              capture_en,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_d,
  output logic              pix_valid,
  output logic [15:0]       pix_data,
  output logic [9:0]        pix_x,
  output logic [8:0]        pix_y,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              frame_start,
  output logic              frame_done,
  output logic              line_err,
  output logic              frame_err
);

  localparam logic [1:0] ST_WAIT_INIT  = 2'd0;
  localparam logic [1:0] ST_WAIT_VS_HI = 2'd1;
  localparam logic [1:0] ST_WAIT_VS_LO = 2'd2;
  localparam logic [1:0] ST_FRAME      = 2'd3;

  localparam logic [9:0] X_MAX = 10'(H_ACTIVE);
  localparam logic [8:0] Y_MAX = 9'(V_ACTIVE);

  logic              pclk_s1, pclk_s2, pclk_s3;
  logic              vsync_s1, vsync_s2, vsync_s3;
  logic              href_s1, href_s2, href_s3;
  logic [7:0]        d_s1, d_s2;

  logic [1:0]        state;
  logic [9:0]        x;
  logic [8:0]        y;
  logic [ADDR_W-1:0] addr_cnt;
  logic [7:0]        hi_byte;
  logic              byte_phase;
  // x and y saturate at the active size, so these remember that a line
  // or frame actually ran past it (otherwise an overlong line/frame
  // would look exactly right at its end).
  logic              x_over;
  logic              y_over;

  logic              pclk_rise, href_fall, vs_rise, vs_fall;
  logic [8:0]        y_line;
  logic              y_over_line;

  // Two-flop synchronisers for the whole camera bus, plus a third stage
  // on the control lines for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk_s1  <= 1'b0; pclk_s2  <= 1'b0; pclk_s3  <= 1'b0;
      vsync_s1 <= 1'b0; vsync_s2 <= 1'b0; vsync_s3 <= 1'b0;
      href_s1  <= 1'b0; href_s2  <= 1'b0; href_s3  <= 1'b0;
      d_s1     <= 8'd0; d_s2     <= 8'd0;
    end else begin
      pclk_s1  <= cam_pclk;  pclk_s2  <= pclk_s1;  pclk_s3  <= pclk_s2;
      vsync_s1 <= cam_vsync; vsync_s2 <= vsync_s1; vsync_s3 <= vsync_s2;
      href_s1  <= cam_href;  href_s2  <= href_s1;  href_s3  <= href_s2;
      d_s1     <= cam_d;     d_s2     <= d_s1;
    end
  end

  assign pclk_rise = pclk_s2 & ~pclk_s3;
  assign href_fall = ~href_s2 & href_s3;
  assign vs_rise   = vsync_s2 & ~vsync_s3;
  assign vs_fall   = ~vsync_s2 & vsync_s3;

  // Row count after this cycle's line end, so a frame end landing in the
  // same cycle already sees the line that just closed.
  always_comb begin
    y_line      = y;
    y_over_line = y_over;
    if (href_fall && (x != 10'd0)) begin
      if (y == Y_MAX) y_over_line = 1'b1;
      else            y_line      = y + 9'd1;
    end
  end

  // Frame-alignment FSM, byte pairing, pixel emission and error tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_WAIT_INIT;
      x           <= 10'd0;
      y           <= 9'd0;
      addr_cnt    <= '0;
      hi_byte     <= 8'd0;
      byte_phase  <= 1'b0;
      x_over      <= 1'b0;
      y_over      <= 1'b0;
      pix_valid   <= 1'b0;
      pix_data    <= 16'd0;
      pix_x       <= 10'd0;
      pix_y       <= 9'd0;
      pix_addr    <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      if (!init_done) begin
        state <= ST_WAIT_INIT;
      end else begin
        case (state)
          ST_WAIT_INIT: state <= ST_WAIT_VS_HI;
          ST_WAIT_VS_HI: begin
            if (vs_rise) state <= ST_WAIT_VS_LO;
          end
          ST_WAIT_VS_LO: begin
            if (vs_fall) begin
              if (capture_en) begin
                state       <= ST_FRAME;
                frame_start <= 1'b1;
                x           <= 10'd0;
                y           <= 9'd0;
                addr_cnt    <= '0;
                byte_phase  <= 1'b0;
                x_over      <= 1'b0;
                y_over      <= 1'b0;
              end else begin
                state <= ST_WAIT_VS_HI;
              end
            end
          end
          ST_FRAME: begin
            if (href_fall) begin
              if ((x != X_MAX) || byte_phase || x_over) line_err <= 1'b1;
              y          <= y_line;
              y_over     <= y_over_line;
              x          <= 10'd0;
              byte_phase <= 1'b0;
              x_over     <= 1'b0;
            end else if (pclk_rise && href_s2) begin
              if (!byte_phase) begin
                hi_byte    <= d_s2;
                byte_phase <= 1'b1;
              end else begin
                byte_phase <= 1'b0;
                if ((x < X_MAX) && (y < Y_MAX)) begin
                  pix_valid <= 1'b1;
                  pix_data  <= {hi_byte, d_s2};
                  pix_x     <= x;
                  pix_y     <= y;
                  pix_addr  <= addr_cnt;
                  addr_cnt  <= addr_cnt + ADDR_W'(1);
                end
                if (x == X_MAX) x_over <= 1'b1;
                else            x      <= x + 10'd1;
              end
            end
            if (vs_rise) begin
              frame_done <= 1'b1;
              if ((y_line != Y_MAX) || y_over_line) frame_err <= 1'b1;
              state <= ST_WAIT_VS_LO;
            end
          end
          default: state <= ST_WAIT_INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Self-checking bench for ov7670_capture: a camera BFM streams frames of
// random bytes at 25 MHz PCLK and a frame-level reference model predicts
// the emitted pixels, pulses and error flags.
module tb_ov7670_capture;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_done = 1'b0;
  logic          capture_en = 1'b0;
  logic          cam_pclk = 1'b0;
  logic          cam_vsync = 1'b0;
  logic          cam_href = 1'b0;
  logic [7:0]    cam_d = 8'd0;
  logic          pix_valid;
  logic [15:0]   pix_data;
  logic [9:0]    pix_x;
  logic [8:0]    pix_y;
  logic [AW-1:0] pix_addr;
  logic          frame_start, frame_done, line_err, frame_err;

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done), .capture_en(capture_en),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_addr(pix_addr), .frame_start(frame_start), .frame_done(frame_done),
    .line_err(line_err), .frame_err(frame_err)
  );

  // 100 MHz system clock
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          x;
    int          y;
    int          addr;
  } pix_t;

  pix_t gotQ[$];
  pix_t expQ[$];
  int   fsCount = 0;
  int   fdCount = 0;
  int   b2bCount = 0;
  logic prevValid = 1'b0;

  int   checkCount = 0;
  int   passCount = 0;

  logic [7:0] lineData[4][16];
  int         lineLen[4];
  int         numLines;
  int         raiseInitLine = -1;
  bit         armed = 1'b0;
  bit         capturedFlag = 1'b0;
  bit         expLineErr = 1'b0;
  bit         expFrameErr = 1'b0;

  // Output monitor, sampling on the falling clk edge
  always @(negedge clk) begin
    pix_t p;
    if (pix_valid) begin
      p.data = pix_data;
      p.x    = int'(pix_x);
      p.y    = int'(pix_y);
      p.addr = int'(pix_addr);
      gotQ.push_back(p);
      if (prevValid) b2bCount++;
    end
    if (frame_start) fsCount++;
    if (frame_done)  fdCount++;
    prevValid = pix_valid;
  end

  // Overall time limit
  initial begin
    #5ms;
    $display("[TB] FAIL timeout: simulation still running at 5 ms, required to finish earlier");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic pclkTick(input logic hr, input logic [7:0] d);
    cam_href = hr;
    cam_d    = d;
    cam_pclk = 1'b0;
    #20;
    cam_pclk = 1'b1;
    #20;
  endtask

  task automatic vsyncFall();
    cam_vsync = 1'b0;
    capturedFlag = armed && init_done && capture_en;
    repeat (2) pclkTick(1'b0, 8'd0);
  endtask

  task automatic vsyncRise();
    cam_vsync = 1'b1;
    if (init_done) armed = 1'b1;
    repeat (3) pclkTick(1'b0, 8'd0);
  endtask

  task automatic setLines(input int n, input int len);
    numLines = n;
    for (int l = 0; l < 4; l++) lineLen[l] = len;
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst.pix_valid",   32'(pix_valid),   32'd0);
    checkOutput("rst.pix_data",    32'(pix_data),    32'd0);
    checkOutput("rst.pix_x",       32'(pix_x),       32'd0);
    checkOutput("rst.pix_y",       32'(pix_y),       32'd0);
    checkOutput("rst.pix_addr",    32'(pix_addr),    32'd0);
    checkOutput("rst.frame_start", 32'(frame_start), 32'd0);
    checkOutput("rst.frame_done",  32'(frame_done),  32'd0);
    checkOutput("rst.line_err",    32'(line_err),    32'd0);
    checkOutput("rst.frame_err",   32'(frame_err),   32'd0);
  endtask

  // Reference model: row = number of earlier lines carrying a whole pixel,
  // pixel p of a line is kept if p<H and row<V, addresses count kept pixels.
  task automatic buildExpected(output bit lineBad, output bit frameBad);
    int row = 0;
    int addr = 0;
    pix_t p;
    expQ.delete();
    lineBad = 1'b0;
    for (int l = 0; l < numLines; l++) begin
      int pairs = lineLen[l] / 2;
      for (int k = 0; k < pairs; k++) begin
        if (k < H && row < V) begin
          p.data = {lineData[l][2*k], lineData[l][2*k+1]};
          p.x    = k;
          p.y    = row;
          p.addr = addr;
          expQ.push_back(p);
          addr++;
        end
      end
      if (lineLen[l] != 2*H) lineBad = 1'b1;
      if (pairs > 0) row++;
    end
    frameBad = (row != V);
  endtask

  // abortKind: 0 none, 1 drop init_done, 2 pulse rst_n; after abortAt pixels sent
  task automatic applyStimulus(input string name, input bit pattern, input int abortKind, input int abortAt);
    logic [7:0] pat = 8'h12;
    int  sent = 0;
    bit  lineBad, frameBad;
    int  nCmp;
    gotQ.delete();
    fsCount = 0;
    fdCount = 0;
    for (int l = 0; l < numLines; l++) begin
      for (int b = 0; b < lineLen[l]; b++) begin
        lineData[l][b] = pattern ? pat : 8'($urandom);
        pat = pat + 8'h22;
      end
    end
    vsyncFall();
    for (int l = 0; l < numLines; l++) begin
      if (l == raiseInitLine) init_done = 1'b1;
      for (int b = 0; b < lineLen[l]; b++) begin
        pclkTick(1'b1, lineData[l][b]);
        if (b % 2 == 1) begin
          sent++;
          if (abortKind != 0 && sent == abortAt) begin
            #40;
            if (abortKind == 1) begin
              init_done = 1'b0;
              armed = 1'b0;
            end else begin
              rst_n = 1'b0;
              #1;
              checkResetOutputs();
              #19;
              rst_n = 1'b1;
              armed = 1'b0;
              expLineErr = 1'b0;
              expFrameErr = 1'b0;
            end
          end
        end
      end
      repeat (1 + $urandom_range(0, 3)) pclkTick(1'b0, 8'd0);
    end
    vsyncRise();
    #200;

    buildExpected(lineBad, frameBad);
    if (!capturedFlag) expQ.delete();
    if (abortKind != 0) begin
      while (expQ.size() > abortAt) void'(expQ.pop_back());
    end else if (capturedFlag) begin
      expLineErr  = expLineErr | lineBad;
      expFrameErr = expFrameErr | frameBad;
    end

    checkOutput({name, ".npix"}, 32'(gotQ.size()), 32'(expQ.size()));
    nCmp = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < nCmp; i++) begin
      checkOutput($sformatf("%s.px%0d.data", name, i), 32'(gotQ[i].data), 32'(expQ[i].data));
      checkOutput($sformatf("%s.px%0d.x", name, i),    32'(gotQ[i].x),    32'(expQ[i].x));
      checkOutput($sformatf("%s.px%0d.y", name, i),    32'(gotQ[i].y),    32'(expQ[i].y));
      checkOutput($sformatf("%s.px%0d.addr", name, i), 32'(gotQ[i].addr), 32'(expQ[i].addr));
    end
    checkOutput({name, ".frame_start"}, 32'(fsCount), capturedFlag ? 32'd1 : 32'd0);
    checkOutput({name, ".frame_done"},  32'(fdCount), (capturedFlag && abortKind == 0) ? 32'd1 : 32'd0);
    checkOutput({name, ".line_err"},    32'(line_err),  32'(expLineErr));
    checkOutput({name, ".frame_err"},   32'(frame_err), 32'(expFrameErr));
  endtask

  // Test sequence
  initial begin
    #12;
    checkResetOutputs();
    #8;
    rst_n = 1'b1;
    capture_en = 1'b1;

    setLines(2, 8);
    applyStimulus("noinit", 1'b0, 0, 0);

    raiseInitLine = 1;
    applyStimulus("midinit", 1'b0, 0, 0);
    raiseInitLine = -1;

    applyStimulus("pattern", 1'b1, 0, 0);
    applyStimulus("rand", 1'b0, 0, 0);

    setLines(2, 8); lineLen[0] = 10;
    applyStimulus("longline", 1'b0, 0, 0);

    setLines(2, 8); lineLen[0] = 7;
    applyStimulus("oddline", 1'b0, 0, 0);

    setLines(3, 8);
    applyStimulus("tallframe", 1'b0, 0, 0);

    setLines(2, 8);
    capture_en = 1'b0;
    applyStimulus("skip", 1'b0, 0, 0);
    capture_en = 1'b1;
    applyStimulus("resume", 1'b0, 0, 0);

    applyStimulus("dropinit", 1'b0, 1, 3);
    init_done = 1'b1;
    applyStimulus("reinit", 1'b0, 0, 0);
    applyStimulus("midreset", 1'b0, 2, 2);
    applyStimulus("final", 1'b0, 0, 0);

    checkOutput("b2b_valid", 32'(b2bCount), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
